i2s_frame_pairer: RTL and testbench

//  Downstream of the I2S receiver. Consumes its per-channel sample stream
//  (data word + strobe + left/right flag). Pairs each left sample with the

---
 rtl/i2s_frame_pairer_pkg.sv | 33 +++
 rtl/i2s_frame_pairer_sync_fifo.sv | 84 ++++++++
 rtl/i2s_frame_pairer.sv | 127 ++++++++++++
 tb/tb_i2s_frame_pairer.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_frame_pairer_pkg.sv
// ----------------------------------------------------------------------------
// i2s_pkg
//   Shared types and constants for the I2S frame pairer.
//   - DEFAULT_BITS_PRECISION : default sample width in bits
//   - stereo_frame_t         : one stereo frame, left sample in the upper half
//   - pair_state_e           : pairing FSM states (waiting for left / holding left)
//   - pack_frame()           : builds a frame from a left and a right sample
// ----------------------------------------------------------------------------
package i2s_pkg;

    localparam int DEFAULT_BITS_PRECISION = 24;

    typedef struct packed {
        logic [DEFAULT_BITS_PRECISION-1:0] l;
        logic [DEFAULT_BITS_PRECISION-1:0] r;
    } stereo_frame_t;

    typedef enum logic {
        WAIT_L = 1'b0,
        HAVE_L = 1'b1
    } pair_state_e;

    function automatic stereo_frame_t pack_frame(
        input logic [DEFAULT_BITS_PRECISION-1:0] left,
        input logic [DEFAULT_BITS_PRECISION-1:0] right
    );
        stereo_frame_t f;
        f.l = left;
        f.r = right;
        return f;
    endfunction

endpackage

// File: rtl/i2s_frame_pairer_sync_fifo.sv
// ----------------------------------------------------------------------------
// sync_fifo
//   Single-clock show-ahead FIFO. The head entry is visible on rd_data
//   whenever the FIFO is not empty, and rd_data is forced to zero when empty.
//   A pop is honoured only when not empty; a push is honoured when not full,
//   or when full but a pop is accepted in the same cycle.
// Ports
//   clk      : clock
//   rst      : asynchronous reset, active-low
//   push     : write request, wr_data is the entry
//   wr_data  : entry to write
//   pop      : remove the head entry
//   rd_data  : head entry (show-ahead), zero when empty
//   full     : count == DEPTH
//   empty    : count == 0
//   count    : entries currently stored (0..DEPTH)
//   dropped  : push refused this cycle because the FIFO was full
// ----------------------------------------------------------------------------
module sync_fifo #(
    parameter  int WIDTH = 48,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count,
    output logic             dropped
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;

    // A pop frees a slot in the same cycle, so a full FIFO still takes a push
    // when the consumer is draining the head at the same edge.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dropped = push && !do_push;

    assign rd_data = empty ? '0 : mem[rd_ptr];

    // Storage is not reset; the empty gating on rd_data hides stale contents.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally at DEPTH (power of two); count is tracked
    // separately so full and empty are unambiguous.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/i2s_frame_pairer.sv
// ----------------------------------------------------------------------------
// i2s_frame_pairer
//   Pairs each left sample from the I2S receiver with the following right
//   sample into a stereo frame, buffers frames in a small FIFO and offers
//   them to the mixer over valid/ready. Reports channel-order errors and
//   FIFO overflow.
// Ports
//   sck            : bit clock, the only clock
//   rst            : asynchronous reset, active-low
//   in_data        : sample from the I2S receiver
//   in_en          : one-cycle strobe qualifying in_data
//   in_left_rightn : 1 = left sample, 0 = right sample
//   out_l_data     : left sample of the head frame (0 when empty)
//   out_r_data     : right sample of the head frame (0 when empty)
//   out_valid      : a head frame is present
//   out_ready      : consumer takes the head frame
//   fifo_count     : frames stored (0..DEPTH)
//   sync_err       : one-cycle pulse per channel-order violation
//   overflow       : sticky, a frame was dropped because the FIFO was full
//   ovf_clr        : synchronous clear of overflow (a new drop wins)
// ----------------------------------------------------------------------------
module i2s_frame_pairer
    import i2s_pkg::*;
#(
    parameter  int BITS_PRECISION = DEFAULT_BITS_PRECISION,
    parameter  int DEPTH          = 4,
    localparam int AW             = $clog2(DEPTH)
) (
    input  logic                      sck,
    input  logic                      rst,
    input  logic [BITS_PRECISION-1:0] in_data,
    input  logic                      in_en,
    input  logic                      in_left_rightn,
    output logic [BITS_PRECISION-1:0] out_l_data,
    output logic [BITS_PRECISION-1:0] out_r_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [AW:0]               fifo_count,
    output logic                      sync_err,
    output logic                      overflow,
    input  logic                      ovf_clr
);

    localparam int FW = 2 * BITS_PRECISION;

    pair_state_e               state;
    logic [BITS_PRECISION-1:0] held_left;
    logic                      frame_push;
    logic [FW-1:0]             frame_data;
    logic [FW-1:0]             head_frame;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic                      fifo_dropped;

    // A frame is completed by a right sample arriving while a left is held.
    assign frame_push = in_en && !in_left_rightn && (state == HAVE_L);
    assign frame_data = {held_left, in_data};

    sync_fifo #(
        .WIDTH (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (sck),
        .rst     (rst),
        .push    (frame_push),
        .wr_data (frame_data),
        .pop     (out_ready),
        .rd_data (head_frame),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count),
        .dropped (fifo_dropped)
    );

    assign out_valid  = !fifo_empty;
    assign out_l_data = head_frame[FW-1:BITS_PRECISION];
    assign out_r_data = head_frame[BITS_PRECISION-1:0];

    // Pairing FSM. A right sample with no held left is discarded; a second
    // left replaces the held one. Both cases raise a one-cycle sync_err.
    always_ff @(posedge sck or negedge rst) begin
        if (!rst) begin
            state     <= WAIT_L;
            held_left <= '0;
            sync_err  <= 1'b0;
        end else begin
            sync_err <= 1'b0;
            if (in_en) begin
                case (state)
                    WAIT_L: begin
                        if (in_left_rightn) begin
                            held_left <= in_data;
                            state     <= HAVE_L;
                        end else begin
                            sync_err  <= 1'b1;
                        end
                    end
                    HAVE_L: begin
                        if (in_left_rightn) begin
                            held_left <= in_data;
                            sync_err  <= 1'b1;
                        end else begin
                            state     <= WAIT_L;
                        end
                    end
                    default: state <= WAIT_L;
                endcase
            end
        end
    end

    // Sticky overflow; a drop in the same cycle as a clear keeps it set.
    always_ff @(posedge sck or negedge rst) begin
        if (!rst) begin
            overflow <= 1'b0;
        end else if (fifo_dropped) begin
            overflow <= 1'b1;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
        end
    end

    // fifo_full is implied by fifo_dropped; kept for visibility in debug.
    logic unused_full;
    assign unused_full = fifo_full;

endmodule

// File: tb/tb_i2s_frame_pairer.sv
// ----------------------------------------------------------------------------
// tb_i2s_frame_pairer
//   Directed bench for i2s_frame_pairer with DEPTH = 4, 24-bit samples.
//   Inputs change on the falling edge, outputs are checked on the falling
//   edge after the rising edge that acted on them.
// ----------------------------------------------------------------------------
module tb_i2s_frame_pairer;

    localparam int BITS  = 24;
    localparam int DEPTH = 4;

    logic            sck = 1'b0;
    logic            rst;
    logic [BITS-1:0] in_data;
    logic            in_en;
    logic            in_left_rightn;
    logic [BITS-1:0] out_l_data;
    logic [BITS-1:0] out_r_data;
    logic            out_valid;
    logic            out_ready;
    logic [2:0]      fifo_count;
    logic            sync_err;
    logic            overflow;
    logic            ovf_clr;

    int checks = 0;
    int errors = 0;
    int sync_pulses = 0;

    i2s_frame_pairer #(
        .BITS_PRECISION (BITS),
        .DEPTH          (DEPTH)
    ) dut (
        .sck            (sck),
        .rst            (rst),
        .in_data        (in_data),
        .in_en          (in_en),
        .in_left_rightn (in_left_rightn),
        .out_l_data     (out_l_data),
        .out_r_data     (out_r_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .fifo_count     (fifo_count),
        .sync_err       (sync_err),
        .overflow       (overflow),
        .ovf_clr        (ovf_clr)
    );

    always #5 sck = ~sck;

    // Count cycles in which sync_err is high, sampled on the rising edge.
    always @(posedge sck) begin
        if (sync_err === 1'b1) begin
            sync_pulses++;
        end
    end

    // One-cycle sample strobe; returns on the falling edge after it was taken.
    task automatic send_sample(input logic lr, input logic [BITS-1:0] d);
        @(negedge sck);
        in_en          = 1'b1;
        in_left_rightn = lr;
        in_data        = d;
        @(negedge sck);
        in_en          = 1'b0;
        in_data        = '0;
    endtask

    task automatic pop_one();
        out_ready = 1'b1;
        @(negedge sck);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; in_en = 1'b0; in_data = '0; in_left_rightn = 1'b0;
        out_ready = 1'b0; ovf_clr = 1'b0;
        #12;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", out_valid); end
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("[TB] FAIL reset_count: got %0d expected 0", fifo_count); end
        checks++; if (out_l_data !== 24'h0 || out_r_data !== 24'h0) begin errors++; $display("[TB] FAIL reset_data: got %h/%h expected 0/0", out_l_data, out_r_data); end
        checks++; if (sync_err !== 1'b0 || overflow !== 1'b0) begin errors++; $display("[TB] FAIL reset_flags: got sync_err=%b overflow=%b expected 0/0", sync_err, overflow); end
        @(negedge sck);
        rst = 1'b1;
        @(negedge sck);
    endtask

    task automatic test_basic_pair();
        int start;
        start = sync_pulses;
        send_sample(1'b1, 24'h000001);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL basic_no_frame_after_left: got %b expected 0", out_valid); end
        send_sample(1'b0, 24'h000002);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL basic_valid: got %b expected 1", out_valid); end
        checks++; if (out_l_data !== 24'h000001 || out_r_data !== 24'h000002) begin errors++; $display("[TB] FAIL basic_data: got %h/%h expected 000001/000002", out_l_data, out_r_data); end
        checks++; if (fifo_count !== 3'd1) begin errors++; $display("[TB] FAIL basic_count: got %0d expected 1", fifo_count); end
        pop_one();
        @(negedge sck);
        checks++; if (out_valid !== 1'b0 || fifo_count !== 3'd0) begin errors++; $display("[TB] FAIL basic_drain: got valid=%b count=%0d expected 0/0", out_valid, fifo_count); end
        checks++; if (sync_pulses - start !== 0) begin errors++; $display("[TB] FAIL basic_no_sync_err: got %0d pulses expected 0", sync_pulses - start); end
    endtask

    task automatic test_right_first();
        int start;
        start = sync_pulses;
        send_sample(1'b0, 24'h000033);
        checks++; if (sync_err !== 1'b1) begin errors++; $display("[TB] FAIL rfirst_sync_err: got %b expected 1", sync_err); end
        send_sample(1'b1, 24'h000005);
        send_sample(1'b0, 24'h000006);
        @(negedge sck);
        checks++; if (sync_pulses - start !== 1) begin errors++; $display("[TB] FAIL rfirst_pulse_count: got %0d expected 1", sync_pulses - start); end
        checks++; if (fifo_count !== 3'd1) begin errors++; $display("[TB] FAIL rfirst_count: got %0d expected 1", fifo_count); end
        checks++; if (out_l_data !== 24'h000005 || out_r_data !== 24'h000006) begin errors++; $display("[TB] FAIL rfirst_data: got %h/%h expected 000005/000006", out_l_data, out_r_data); end
        pop_one();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rfirst_drain: got %b expected 0", out_valid); end
    endtask

    task automatic test_double_left();
        int start;
        start = sync_pulses;
        send_sample(1'b1, 24'h000007);
        send_sample(1'b1, 24'h000008);
        send_sample(1'b0, 24'h000009);
        @(negedge sck);
        checks++; if (sync_pulses - start !== 1) begin errors++; $display("[TB] FAIL dleft_pulse_count: got %0d expected 1", sync_pulses - start); end
        checks++; if (fifo_count !== 3'd1) begin errors++; $display("[TB] FAIL dleft_count: got %0d expected 1", fifo_count); end
        checks++; if (out_l_data !== 24'h000008 || out_r_data !== 24'h000009) begin errors++; $display("[TB] FAIL dleft_data: got %h/%h expected 000008/000009", out_l_data, out_r_data); end
        pop_one();
    endtask

    task automatic test_pop_empty();
        out_ready = 1'b1;
        @(negedge sck);
        @(negedge sck);
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0 || fifo_count !== 3'd0) begin errors++; $display("[TB] FAIL pop_empty: got valid=%b count=%0d expected 0/0", out_valid, fifo_count); end
        checks++; if (out_l_data !== 24'h0) begin errors++; $display("[TB] FAIL pop_empty_data: got %h expected 0", out_l_data); end
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= 5; i++) begin
            send_sample(1'b1, 24'h000010 + 24'(i));
            send_sample(1'b0, 24'h000020 + 24'(i));
        end
        checks++; if (fifo_count !== 3'd4) begin errors++; $display("[TB] FAIL ovf_count: got %0d expected 4", fifo_count); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("[TB] FAIL ovf_set: got %b expected 1", overflow); end
        checks++; if (out_l_data !== 24'h000011 || out_r_data !== 24'h000021) begin errors++; $display("[TB] FAIL ovf_head: got %h/%h expected 000011/000021", out_l_data, out_r_data); end
        // A drop coinciding with a clear must leave overflow set.
        send_sample(1'b1, 24'h000016);
        @(negedge sck);
        in_en = 1'b1; in_left_rightn = 1'b0; in_data = 24'h000026; ovf_clr = 1'b1;
        @(negedge sck);
        in_en = 1'b0; in_data = '0; ovf_clr = 1'b0;
        checks++; if (overflow !== 1'b1) begin errors++; $display("[TB] FAIL ovf_set_priority: got %b expected 1", overflow); end
        for (int i = 1; i <= 4; i++) begin
            checks++; if (out_valid !== 1'b1 || out_l_data !== 24'h000010 + 24'(i) || out_r_data !== 24'h000020 + 24'(i)) begin
                errors++; $display("[TB] FAIL ovf_drain_%0d: got valid=%b %h/%h expected 1 %h/%h", i, out_valid, out_l_data, out_r_data, 24'h000010 + 24'(i), 24'h000020 + 24'(i));
            end
            pop_one();
        end
        checks++; if (out_valid !== 1'b0 || fifo_count !== 3'd0) begin errors++; $display("[TB] FAIL ovf_empty: got valid=%b count=%0d expected 0/0", out_valid, fifo_count); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("[TB] FAIL ovf_sticky: got %b expected 1", overflow); end
        ovf_clr = 1'b1;
        @(negedge sck);
        ovf_clr = 1'b0;
        checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL ovf_clear: got %b expected 0", overflow); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            send_sample(1'b1, 24'h000041 + 24'(i));
            send_sample(1'b0, 24'h000051 + 24'(i));
        end
        checks++; if (fifo_count !== 3'd4) begin errors++; $display("[TB] FAIL b2b_full: got %0d expected 4", fifo_count); end
        send_sample(1'b1, 24'h000045);
        @(negedge sck);
        in_en = 1'b1; in_left_rightn = 1'b0; in_data = 24'h000055; out_ready = 1'b1;
        @(negedge sck);
        in_en = 1'b0; in_data = '0; out_ready = 1'b0;
        checks++; if (fifo_count !== 3'd4) begin errors++; $display("[TB] FAIL b2b_count: got %0d expected 4", fifo_count); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL b2b_no_overflow: got %b expected 0", overflow); end
        for (int i = 1; i <= 4; i++) begin
            checks++; if (out_valid !== 1'b1 || out_l_data !== 24'h000041 + 24'(i) || out_r_data !== 24'h000051 + 24'(i)) begin
                errors++; $display("[TB] FAIL b2b_drain_%0d: got valid=%b %h/%h expected 1 %h/%h", i, out_valid, out_l_data, out_r_data, 24'h000041 + 24'(i), 24'h000051 + 24'(i));
            end
            pop_one();
        end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_empty: got %b expected 0", out_valid); end
    endtask

    task automatic test_mid_reset();
        int start;
        send_sample(1'b1, 24'h000061);
        send_sample(1'b0, 24'h000062);
        send_sample(1'b1, 24'h000063);
        send_sample(1'b0, 24'h000064);
        send_sample(1'b1, 24'h000065);
        checks++; if (fifo_count !== 3'd2) begin errors++; $display("[TB] FAIL mrst_precount: got %0d expected 2", fifo_count); end
        #2 rst = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || fifo_count !== 3'd0) begin errors++; $display("[TB] FAIL mrst_async: got valid=%b count=%0d expected 0/0", out_valid, fifo_count); end
        @(negedge sck);
        rst = 1'b1;
        start = sync_pulses;
        send_sample(1'b0, 24'h000066);
        @(negedge sck);
        checks++; if (sync_pulses - start !== 1) begin errors++; $display("[TB] FAIL mrst_sync_err: got %0d pulses expected 1", sync_pulses - start); end
        checks++; if (out_valid !== 1'b0 || fifo_count !== 3'd0) begin errors++; $display("[TB] FAIL mrst_no_frame: got valid=%b count=%0d expected 0/0", out_valid, fifo_count); end
    endtask

    initial begin
        test_reset();
        test_basic_pair();
        test_right_first();
        test_double_left();
        test_pop_empty();
        test_overflow();
        test_back_to_back();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
